arbitro_multiplicador_fp13: RTL and testbench

Sequencer and arbiter that shares one combinational 13-bit floating-point multiplier (sign 1b | exponent 4b, bias 7 | mantissa 8b) between two requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants the multiplier round-robin, registers the operands and holds them on the multiplier inputs. It waits a programmable settle time, then captures the product and returns it to the granted requester with a valid/ready response handshake. It sits between the requester logic and the multiplier datapath, one level above it.

---
 rtl/arbitro_multiplicador_fp13_pkg.sv | 30 +++
 rtl/arbitro_multiplicador_fp13_rr2.sv | 19 +
 rtl/arbitro_multiplicador_fp13.sv | 111 +++++++++++
 tb/tb_arbitro_multiplicador_fp13.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_multiplicador_fp13_pkg.sv
// Shared definitions for the fp13 multiplier arbiter: word layout, counter width and FSM encodings.
// Word layout: sign 1b | exponent 4b (bias 7) | mantissa 8b.
package arbitro_multiplicador_fp13_pkg;

    localparam int FP_NB_DATA      = 13;
    localparam int NB_SIGNO        = 1;
    localparam int NB_EXPONENTE    = 4;
    localparam int NB_MANTISA      = 8;
    localparam int SESGO_EXPONENTE = 7;

    // Wide enough for the largest settle time (15 cycles).
    localparam int NB_CONTADOR = 4;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CAPTURA   = 2'd1;
    localparam logic [1:0] ST_ESPERA    = 2'd2;
    localparam logic [1:0] ST_RESPUESTA = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        CAPTURA   = ST_CAPTURA,
        ESPERA    = ST_ESPERA,
        RESPUESTA = ST_RESPUESTA
    } estado_t;

    function automatic logic [1:0] one_hot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arbitro_multiplicador_fp13_rr2.sv
// Two-input round-robin selector: on a tie the requester that was not served last wins.
module arbitro_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant       = 1'b0;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req == 2'b10) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_multiplicador_fp13.sv
// Shares one combinational fp13 multiplier between two requesters: grants round-robin,
// holds the operands for LATENCIA cycles, then returns the product over a valid/ready response.
module arbitro_multiplicador_fp13
    import arbitro_multiplicador_fp13_pkg::*;
#(
    parameter int NB_DATA  = FP_NB_DATA,
    parameter int LATENCIA = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [1:0]         i_req_valid,
    output logic [1:0]         o_req_ready,
    input  logic [NB_DATA-1:0] i_op_a_0,
    input  logic [NB_DATA-1:0] i_op_b_0,
    input  logic [NB_DATA-1:0] i_op_a_1,
    input  logic [NB_DATA-1:0] i_op_b_1,
    output logic [1:0]         o_resp_valid,
    input  logic [1:0]         i_resp_ready,
    output logic [NB_DATA-1:0] o_resultado,
    output logic [NB_DATA-1:0] o_mul_op_1,
    output logic [NB_DATA-1:0] o_mul_op_2,
    input  logic [NB_DATA-1:0] i_mul_resultado,
    output logic               o_ocupado,
    output logic               o_grant
);

    localparam logic [NB_CONTADOR-1:0] CONTADOR_CARGA = NB_CONTADOR'(LATENCIA - 1);

    estado_t                estado_reg;
    logic [NB_CONTADOR-1:0] contador_reg;
    logic                   last_reg;
    logic                   grant_reg;
    logic [NB_DATA-1:0]     op_1_reg;
    logic [NB_DATA-1:0]     op_2_reg;
    logic [NB_DATA-1:0]     resultado_reg;
    logic [1:0]             resp_valid_reg;

    logic                   sel_grant;
    logic                   sel_valid;
    logic                   acepta;
    logic [NB_DATA-1:0]     op_a_sel;
    logic [NB_DATA-1:0]     op_b_sel;

    arbitro_rr2 u_arbitro (
        .req         (i_req_valid),
        .last        (last_reg),
        .grant       (sel_grant),
        .grant_valid (sel_valid)
    );

    // The accept pulse is combinational so a requester sees it in the same cycle the grant is decided.
    assign acepta      = (estado_reg == IDLE) && sel_valid && !i_reset;
    assign o_req_ready = acepta ? one_hot2(sel_grant) : 2'b00;

    assign op_a_sel = sel_grant ? i_op_a_1 : i_op_a_0;
    assign op_b_sel = sel_grant ? i_op_b_1 : i_op_b_0;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            estado_reg     <= IDLE;
            contador_reg   <= '0;
            last_reg       <= 1'b1;
            grant_reg      <= 1'b0;
            op_1_reg       <= '0;
            op_2_reg       <= '0;
            resultado_reg  <= '0;
            resp_valid_reg <= 2'b00;
        end else begin
            case (estado_reg)
                IDLE: begin
                    if (sel_valid) begin
                        op_1_reg   <= op_a_sel;
                        op_2_reg   <= op_b_sel;
                        grant_reg  <= sel_grant;
                        last_reg   <= sel_grant;
                        estado_reg <= CAPTURA;
                    end
                end
                CAPTURA: begin
                    contador_reg <= CONTADOR_CARGA;
                    estado_reg   <= ESPERA;
                end
                ESPERA: begin
                    // The product is sampled only on the final settle cycle.
                    if (contador_reg != '0) begin
                        contador_reg <= contador_reg - 1'b1;
                    end else begin
                        resultado_reg  <= i_mul_resultado;
                        resp_valid_reg <= one_hot2(grant_reg);
                        estado_reg     <= RESPUESTA;
                    end
                end
                RESPUESTA: begin
                    if (i_resp_ready[grant_reg]) begin
                        resp_valid_reg <= 2'b00;
                        estado_reg     <= IDLE;
                    end
                end
                default: estado_reg <= IDLE;
            endcase
        end
    end

    assign o_mul_op_1   = op_1_reg;
    assign o_mul_op_2   = op_2_reg;
    assign o_resultado  = resultado_reg;
    assign o_resp_valid = resp_valid_reg;
    assign o_grant      = grant_reg;
    assign o_ocupado    = (estado_reg != IDLE);

endmodule

// File: tb/tb_arbitro_multiplicador_fp13.sv
// Bench for the fp13 multiplier arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (round-robin rule, latency, fp13 multiply).
module tb_arbitro_multiplicador_fp13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [12:0] op_a_0 = '0, op_b_0 = '0, op_a_1 = '0, op_b_1 = '0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b00;
    logic [12:0] resultado, mul_op_1, mul_op_2, mul_res;
    logic        ocupado, grant;

    logic [1:0]  req_valid4 = 2'b00;
    logic [1:0]  req_ready4;
    logic [1:0]  resp_valid4;
    logic [1:0]  resp_ready4 = 2'b00;
    logic [12:0] resultado4, mul_op_1_4, mul_op_2_4;
    logic [12:0] mul_res4 = '0;
    logic        ocupado4, grant4;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          model_last = 1'b1;
    logic [12:0] last_obs_res;

    always #5 clk = ~clk;

    // Reference fp13 multiply: value = (-1)^s * (1 + m/256) * 2^(e-7), truncated.
    function automatic logic [12:0] fp_mul(input logic [12:0] a, input logic [12:0] b);
        logic        s;
        int          e;
        int unsigned p;
        s = a[12] ^ b[12];
        if (a[11:0] == 12'd0 || b[11:0] == 12'd0) return {s, 12'd0};
        p = (256 + int'(a[7:0])) * (256 + int'(b[7:0]));
        e = int'(a[11:8]) + int'(b[11:8]) - 7;
        if (p >= 131072) begin
            p = p >> 9;
            e = e + 1;
        end else begin
            p = p >> 8;
        end
        if (e > 15) return {s, 4'hF, 8'hFF};
        if (e < 0)  return {s, 12'd0};
        return {s, 4'(e), 8'(p)};
    endfunction

    assign mul_res = fp_mul(mul_op_1, mul_op_2);

    arbitro_multiplicador_fp13 #(.NB_DATA(13), .LATENCIA(1)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_op_a_0        (op_a_0),
        .i_op_b_0        (op_b_0),
        .i_op_a_1        (op_a_1),
        .i_op_b_1        (op_b_1),
        .o_resp_valid    (resp_valid),
        .i_resp_ready    (resp_ready),
        .o_resultado     (resultado),
        .o_mul_op_1      (mul_op_1),
        .o_mul_op_2      (mul_op_2),
        .i_mul_resultado (mul_res),
        .o_ocupado       (ocupado),
        .o_grant         (grant)
    );

    arbitro_multiplicador_fp13 #(.NB_DATA(13), .LATENCIA(4)) dut4 (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_req_valid     (req_valid4),
        .o_req_ready     (req_ready4),
        .i_op_a_0        (op_a_0),
        .i_op_b_0        (op_b_0),
        .i_op_a_1        (op_a_1),
        .i_op_b_1        (op_b_1),
        .o_resp_valid    (resp_valid4),
        .i_resp_ready    (resp_ready4),
        .o_resultado     (resultado4),
        .o_mul_op_1      (mul_op_1_4),
        .o_mul_op_2      (mul_op_2_4),
        .i_mul_resultado (mul_res4),
        .o_ocupado       (ocupado4),
        .o_grant         (grant4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nsample();
        @(negedge clk);
        #1;
    endtask

    task automatic new_ops(input int k);
        if (k == 0) begin
            op_a_0 = 13'($urandom);
            op_b_0 = 13'($urandom);
        end else begin
            op_a_1 = 13'($urandom);
            op_b_1 = 13'($urandom);
        end
    endtask

    // One complete transaction seen from the requester side; the model decides who must win.
    task automatic serve(input int hold, input bit renew, output int wait_cyc);
        int          g, cyc;
        logic [1:0]  oh;
        logic [12:0] ea, eb, er;
        cyc = 0;
        while (req_ready === 2'b00 && cyc < 20) begin
            nsample();
            cyc++;
        end
        wait_cyc = cyc;
        if (req_valid == 2'b11)  g = model_last ? 0 : 1;
        else if (req_valid[0])   g = 0;
        else                     g = 1;
        oh = (g == 1) ? 2'b10 : 2'b01;
        ea = (g == 1) ? op_a_1 : op_a_0;
        eb = (g == 1) ? op_b_1 : op_b_0;
        er = fp_mul(ea, eb);
        check("req_ready", 32'(req_ready), 32'(oh));
        check("ocupado_idle", 32'(ocupado), 0);
        model_last = g[0];
        @(posedge clk);
        #1;
        if (renew) new_ops(g);
        else       req_valid[g] = 1'b0;
        nsample();
        check("mul_op_1", 32'(mul_op_1), 32'(ea));
        check("mul_op_2", 32'(mul_op_2), 32'(eb));
        check("grant", 32'(grant), 32'(g));
        check("ocupado_busy", 32'(ocupado), 1);
        cyc = 1;
        while (resp_valid === 2'b00 && cyc < 30) begin
            check("no_ready_busy", 32'(req_ready), 0);
            nsample();
            cyc++;
        end
        check("latency", 32'(cyc), 3);
        check("resp_valid", 32'(resp_valid), 32'(oh));
        check("resultado", 32'(resultado), 32'(er));
        last_obs_res = resultado;
        for (int h = 0; h < hold; h++) begin
            resp_ready[g]     = 1'b0;
            resp_ready[1 - g] = 1'b1;
            nsample();
            check("hold_valid", 32'(resp_valid), 32'(oh));
            check("hold_result", 32'(resultado), 32'(er));
            check("hold_no_ready", 32'(req_ready), 0);
        end
        resp_ready[g] = 1'b1;
        nsample();
        check("resp_cleared", 32'(resp_valid), 0);
        check("back_idle", 32'(ocupado), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [12:0] good;

        // 1. Asynchronous reset before any clock edge, then idle.
        #2;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resultado", 32'(resultado), 0);
        check("rst_mul_op_1", 32'(mul_op_1), 0);
        check("rst_mul_op_2", 32'(mul_op_2), 0);
        check("rst_ocupado", 32'(ocupado), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_ocupado4", 32'(ocupado4), 0);
        nsample();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nsample();
            check("idle_ocupado", 32'(ocupado), 0);
            check("idle_ready", 32'(req_ready), 0);
        end

        // 2. Single request 1.5 * 2.0.
        op_a_0 = 13'h0780;
        op_b_0 = 13'h0800;
        req_valid = 2'b01;
        #1;
        serve(2, 1'b0, w);
        check("t2_result_3p0", 32'(last_obs_res), 32'h0880);

        // 3. Both requesting continuously with response ready high: grants alternate.
        resp_ready = 2'b11;
        new_ops(0);
        new_ops(1);
        req_valid = 2'b11;
        #1;
        for (int t = 0; t < 5; t++) begin
            serve(0, 1'b1, w);
        end

        // 4. Back-pressure on requester 0 with requester 1 pending.
        serve(5, 1'b0, w);
        serve(0, 1'b0, w);
        check("t4_grant_first_idle", 32'(w), 0);

        // 5. LATENCIA=4 instance: only the last settle cycle is sampled.
        op_a_0 = 13'h0a40;
        op_b_0 = 13'h06c0;
        good = fp_mul(op_a_0, op_b_0);
        mul_res4 = ~good;
        req_valid4 = 2'b01;
        #1;
        check("t5_ready", 32'(req_ready4), 32'h1);
        @(posedge clk);
        #1;
        req_valid4 = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            nsample();
            if (k < 6) begin
                check("t5_wait", 32'(resp_valid4), 0);
                mul_res4 = (k == 5) ? good : (good ^ 13'($urandom_range(1, 8191)));
            end
        end
        check("t5_resp_valid", 32'(resp_valid4), 32'h1);
        check("t5_resultado", 32'(resultado4), 32'(good));
        resp_ready4 = 2'b01;
        nsample();
        check("t5_cleared", 32'(resp_valid4), 0);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            logic [1:0] add;
            add = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                if (add[k] && !req_valid[k]) begin
                    new_ops(k);
                    req_valid[k] = 1'b1;
                end
            end
            #1;
            serve(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w);
        end

        // 6. Reset during ESPERA aborts the transaction.
        req_valid = 2'b00;
        resp_ready = 2'b00;
        op_a_0 = 13'h0b55;
        op_b_0 = 13'h07aa;
        req_valid = 2'b01;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        nsample();
        check("t6_captura", 32'(ocupado), 1);
        nsample();
        check("t6_espera_busy", 32'(ocupado), 1);
        check("t6_espera_resp", 32'(resp_valid), 0);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_ocupado", 32'(ocupado), 0);
        check("t6_rst_mul_op_1", 32'(mul_op_1), 0);
        check("t6_rst_mul_op_2", 32'(mul_op_2), 0);
        check("t6_rst_resultado", 32'(resultado), 0);
        check("t6_rst_resp_valid", 32'(resp_valid), 0);
        nsample();
        rst = 1'b0;
        model_last = 1'b1;
        resp_ready = 2'b11;
        for (int i = 0; i < 5; i++) begin
            nsample();
            check("t6_no_resp", 32'(resp_valid), 0);
        end
        new_ops(0);
        new_ops(1);
        req_valid = 2'b11;
        #1;
        check("t6_tie_to_0", 32'(req_ready), 32'h1);
        serve(0, 1'b0, w);
        serve(0, 1'b0, w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
